int_sequencer: RTL and testbench

//  Interrupt-entry sequencer: drives int/count into the hazard detection unit, the other end of

---
 rtl/int_sequencer_pkg.sv | 28 ++
 rtl/int_sequencer_if.sv | 49 ++++
 rtl/int_sequencer.sv | 139 +++++++++++++
 tb/tb_int_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/int_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : int_sequencer_pkg
//  Description : Shared constants for the interrupt-entry sequencer: state
//                encoding, count step values and default vector address.
//  Revision    : 1.0  initial release
// ============================================================================
package int_sequencer_pkg;

    // Sequencer state encoding (3 bits)
    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PC_HI  = 3'd1;
    localparam logic [2:0] c_ST_PC_LO  = 3'd2;
    localparam logic [2:0] c_ST_FLAGS  = 3'd3;
    localparam logic [2:0] c_ST_VEC_RD = 3'd4;
    localparam logic [2:0] c_ST_VEC_LD = 3'd5;

    // Step numbers reported to the hazard detection unit
    localparam logic [1:0] c_CNT_IDLE  = 2'd0;
    localparam logic [1:0] c_CNT_PC_HI = 2'd1;
    localparam logic [1:0] c_CNT_PC_LO = 2'd2;
    localparam logic [1:0] c_CNT_TAIL  = 2'd3;

    // Memory address holding the handler entry point
    localparam int unsigned c_VEC_ADDR_DEFAULT = 0;

endpackage
`default_nettype wire

// File: rtl/int_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : int_sequencer_if
//  Description : Bundle between the interrupt sequencer, the pipeline/HDU
//                and the memory stage. The sequencer is the master.
//                The HDU "int" signal is named int_active because int is a
//                reserved word.
//  Revision    : 1.0  initial release
// ============================================================================
interface int_sequencer_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 32,
    parameter int FLAG_W = 3
);
    // Pipeline / environment inputs to the sequencer
    logic              int_req;
    logic              stall;
    logic              branch_out;
    logic              ret;
    logic              rti_done;
    logic [PC_W-1:0]   pc_in;
    logic [FLAG_W-1:0] flags_in;
    logic [DATA_W-1:0] vec_data;

    // Sequencer outputs
    logic              int_active;
    logic [1:0]        count;
    logic              push_en;
    logic [DATA_W-1:0] push_data;
    logic              vec_rd;
    logic [DATA_W-1:0] vec_addr;
    logic              pc_load;
    logic [PC_W-1:0]   pc_load_val;
    logic              in_isr;

    modport master (
        input  int_req, stall, branch_out, ret, rti_done, pc_in, flags_in, vec_data,
        output int_active, count, push_en, push_data, vec_rd, vec_addr,
               pc_load, pc_load_val, in_isr
    );

    modport slave (
        output int_req, stall, branch_out, ret, rti_done, pc_in, flags_in, vec_data,
        input  int_active, count, push_en, push_data, vec_rd, vec_addr,
               pc_load, pc_load_val, in_isr
    );

endinterface
`default_nettype wire

// File: rtl/int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : int_sequencer
//  Description : Interrupt-entry sequencer. Latches an interrupt request,
//                waits for a quiet pipeline, pushes the return PC (hi, lo)
//                and flags, reads the handler vector and loads the PC.
//                All control outputs are registered alongside the state.
//  Revision    : 1.0  initial release
// ============================================================================
module int_sequencer
    import int_sequencer_pkg::*;
#(
    parameter int          DATA_W   = 16,
    parameter int          PC_W     = 32,
    parameter int          FLAG_W   = 3,
    parameter int unsigned VEC_ADDR = c_VEC_ADDR_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    int_sequencer_if.master  bus
);

    logic [2:0]        r_state;
    logic              r_pending;
    logic              r_in_isr;
    logic [DATA_W-1:0] r_ret_pc_lo;   // hi word is pushed straight from pc_in
    logic [FLAG_W-1:0] r_sav_flags;
    logic              r_int;
    logic [1:0]        r_count;
    logic              r_push_en;
    logic [DATA_W-1:0] r_push_data;
    logic              r_vec_rd;
    logic              r_pc_load;

    logic              w_quiet;
    logic              w_enter;

    // Entry needs a latched request, unmasked, with nothing in flight
    assign w_quiet = !bus.stall && !bus.branch_out && !bus.ret;
    assign w_enter = (r_state == c_ST_IDLE) && r_pending && !r_in_isr && w_quiet;

    // Request latch and handler mask; entry clears pending, last step masks
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending <= 1'b0;
            r_in_isr  <= 1'b0;
        end else begin
            if (w_enter) begin
                r_pending <= 1'b0;
            end else if (bus.int_req) begin
                r_pending <= 1'b1;
            end

            if (r_state == c_ST_VEC_LD) begin
                r_in_isr <= 1'b1;
            end else if (bus.rti_done) begin
                r_in_isr <= 1'b0;
            end
        end
    end

    // Sequencer FSM with outputs registered together with the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_ret_pc_lo <= '0;
            r_sav_flags <= '0;
            r_int       <= 1'b0;
            r_count     <= c_CNT_IDLE;
            r_push_en   <= 1'b0;
            r_push_data <= '0;
            r_vec_rd    <= 1'b0;
            r_pc_load   <= 1'b0;
        end else begin
            r_push_en <= 1'b0;
            r_vec_rd  <= 1'b0;
            r_pc_load <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_enter) begin
                        r_state     <= c_ST_PC_HI;
                        r_ret_pc_lo <= bus.pc_in[DATA_W-1:0];
                        r_sav_flags <= bus.flags_in;
                        r_int       <= 1'b1;
                        r_count     <= c_CNT_PC_HI;
                        r_push_en   <= 1'b1;
                        r_push_data <= DATA_W'(bus.pc_in >> DATA_W);
                    end else begin
                        r_int   <= 1'b0;
                        r_count <= c_CNT_IDLE;
                    end
                end
                c_ST_PC_HI: begin
                    r_state     <= c_ST_PC_LO;
                    r_count     <= c_CNT_PC_LO;
                    r_push_en   <= 1'b1;
                    r_push_data <= r_ret_pc_lo;
                end
                c_ST_PC_LO: begin
                    r_state     <= c_ST_FLAGS;
                    r_count     <= c_CNT_TAIL;
                    r_push_en   <= 1'b1;
                    r_push_data <= {{(DATA_W-FLAG_W){1'b0}}, r_sav_flags};
                end
                c_ST_FLAGS: begin
                    r_state  <= c_ST_VEC_RD;
                    r_vec_rd <= 1'b1;
                end
                c_ST_VEC_RD: begin
                    r_state   <= c_ST_VEC_LD;
                    r_pc_load <= 1'b1;
                end
                c_ST_VEC_LD: begin
                    r_state <= c_ST_IDLE;
                    r_int   <= 1'b0;
                    r_count <= c_CNT_IDLE;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_int   <= 1'b0;
                    r_count <= c_CNT_IDLE;
                end
            endcase
        end
    end

    assign bus.int_active  = r_int;
    assign bus.count       = r_count;
    assign bus.push_en     = r_push_en;
    assign bus.push_data   = r_push_data;
    assign bus.vec_rd      = r_vec_rd;
    assign bus.vec_addr    = DATA_W'(VEC_ADDR);
    assign bus.pc_load     = r_pc_load;
    // Vector word arrives the cycle after vec_rd, i.e. during the pc_load pulse
    assign bus.pc_load_val = {{(PC_W-DATA_W){1'b0}}, bus.vec_data};
    assign bus.in_isr      = r_in_isr;

endmodule
`default_nettype wire

// File: tb/tb_int_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_int_sequencer
//  Description : Self-checking bench for int_sequencer. A transaction-level
//                model expands each accepted interrupt into its five output
//                steps and compares every cycle.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_int_sequencer;

    localparam int DATA_W   = 16;
    localparam int PC_W     = 32;
    localparam int FLAG_W   = 3;
    localparam int VEC_ADDR = 0;

    typedef struct packed {
        logic        act;
        logic [1:0]  cnt;
        logic        push;
        logic [15:0] data;
        logic        rd;
        logic        ld;
    } step_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int_sequencer_if #(.DATA_W(DATA_W), .PC_W(PC_W), .FLAG_W(FLAG_W)) bus ();

    int_sequencer #(
        .DATA_W(DATA_W), .PC_W(PC_W), .FLAG_W(FLAG_W), .VEC_ADDR(VEC_ADDR)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    step_t       q[$];
    step_t       cur;
    bit          m_pending;
    bit          m_isr;
    logic [15:0] handler;
    logic [15:0] push_log[$];
    int          n_cmp = 0;
    int          n_err = 0;

    function automatic step_t mk(logic [1:0] cnt, logic push, logic [15:0] data,
                                 logic rd, logic ld);
        step_t s;
        s.act = 1'b1; s.cnt = cnt; s.push = push; s.data = data; s.rd = rd; s.ld = ld;
        return s;
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference behaviour at one rising edge, from the inputs held at that edge
    task automatic model_edge();
        bit entry;
        bit prev_rd;
        prev_rd = cur.rd;
        if (rst) begin
            m_pending = 0;
            m_isr     = 0;
            q.delete();
            cur = '0;
        end else begin
            entry = !cur.act && m_pending && !m_isr &&
                    !bus.stall && !bus.branch_out && !bus.ret;
            m_isr     = cur.ld ? 1'b1 : (bus.rti_done ? 1'b0 : m_isr);
            m_pending = entry ? 1'b0 : (m_pending | bus.int_req);
            if (entry) begin
                cur = mk(2'd1, 1'b1, bus.pc_in[31:16], 1'b0, 1'b0);
                q.push_back(mk(2'd2, 1'b1, bus.pc_in[15:0], 1'b0, 1'b0));
                q.push_back(mk(2'd3, 1'b1, {13'b0, bus.flags_in}, 1'b0, 1'b0));
                q.push_back(mk(2'd3, 1'b0, 16'h0, 1'b1, 1'b0));
                q.push_back(mk(2'd3, 1'b0, 16'h0, 1'b0, 1'b1));
            end else if (q.size() > 0) begin
                cur = q.pop_front();
            end else begin
                cur = '0;
            end
        end
        // Memory returns the vector only in the cycle after a read
        bus.vec_data = prev_rd ? handler : 16'($urandom);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("int",      bus.int_active, cur.act);
        chk("count",    bus.count,      cur.cnt);
        chk("push_en",  bus.push_en,    cur.push);
        if (cur.push) chk("push_data", bus.push_data, cur.data);
        chk("vec_rd",   bus.vec_rd,     cur.rd);
        chk("pc_load",  bus.pc_load,    cur.ld);
        if (cur.ld) chk("pc_load_val", bus.pc_load_val, {16'h0, handler});
        chk("in_isr",   bus.in_isr,     m_isr);
        chk("vec_addr", bus.vec_addr,   VEC_ADDR);
        if (bus.push_en) push_log.push_back(bus.push_data);
        @(negedge clk);
    endtask

    task automatic rti_pulse();
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
        tick();
    endtask

    initial begin
        logic [31:0] pc_b;
        cur = '0;
        rst = 1'b1;
        bus.int_req = 0; bus.stall = 0; bus.branch_out = 0; bus.ret = 0;
        bus.rti_done = 0; bus.pc_in = '0; bus.flags_in = '0; bus.vec_data = '0;
        handler = 16'h0200;
        tick();
        tick();
        chk("reset_isr", bus.in_isr, 1'b0);
        rst = 1'b0;
        tick();

        // 1: basic sequence
        bus.pc_in = 32'h0001_0040; bus.flags_in = 3'b101;
        push_log.delete();
        bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
        repeat (8) tick();
        chk("t1_npush", push_log.size(), 3);
        if (push_log.size() == 3) begin
            chk("t1_w0", push_log[0], 16'h0001);
            chk("t1_w1", push_log[1], 16'h0040);
            chk("t1_w2", push_log[2], 16'h0005);
        end
        chk("t1_isr", bus.in_isr, 1'b1);
        rti_pulse();

        // 2: request during a 3-cycle stall; captured PC is the one after stall
        handler = 16'($urandom);
        bus.stall = 1'b1; bus.int_req = 1'b1;
        bus.pc_in = $urandom;
        tick();
        bus.int_req = 1'b0;
        bus.pc_in = $urandom;
        tick();
        tick();
        bus.stall = 1'b0;
        pc_b = $urandom; bus.pc_in = pc_b; bus.flags_in = 3'($urandom);
        push_log.delete();
        tick();
        bus.pc_in = $urandom;
        repeat (7) tick();
        chk("t2_npush", push_log.size(), 3);
        if (push_log.size() == 3) chk("t2_hi", push_log[0], pc_b[31:16]);

        // 3: masked while in handler; rti releases the held request
        push_log.delete();
        bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
        repeat (4) tick();
        chk("t3_masked", push_log.size(), 0);
        bus.rti_done = 1'b1;
        tick();
        bus.rti_done = 1'b0;
        repeat (7) tick();
        chk("t3_npush", push_log.size(), 3);
        rti_pulse();

        // 4: reset during PC_LO aborts, no FLAGS push
        push_log.delete();
        bus.int_req = 1'b1;
        tick();
        bus.int_req = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (4) tick();
        chk("t4_npush", push_log.size(), 2);
        chk("t4_int", bus.int_active, 1'b0);

        // 5: deferred by branch_out then ret
        push_log.delete();
        bus.int_req = 1'b1; bus.branch_out = 1'b1;
        tick();
        bus.int_req = 1'b0;
        tick();
        bus.branch_out = 1'b0; bus.ret = 1'b1;
        tick();
        tick();
        chk("t5_wait", push_log.size(), 0);
        bus.ret = 1'b0;
        repeat (8) tick();
        chk("t5_npush", push_log.size(), 3);

        // 6: level request held 10 cycles -> one sequence
        rti_pulse();
        push_log.delete();
        bus.int_req = 1'b1;
        repeat (10) tick();
        bus.int_req = 1'b0;
        repeat (6) tick();
        chk("t6_npush", push_log.size(), 3);
        rti_pulse();
        repeat (8) tick();
        rti_pulse();

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 39) == 0) handler = 16'($urandom);
            bus.int_req    = ($urandom_range(0, 7) == 0);
            bus.stall      = ($urandom_range(0, 3) == 0);
            bus.branch_out = ($urandom_range(0, 5) == 0);
            bus.ret        = ($urandom_range(0, 7) == 0);
            bus.rti_done   = ($urandom_range(0, 9) == 0);
            bus.pc_in      = $urandom;
            bus.flags_in   = 3'($urandom);
            rst            = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
